register_file: RTL and testbench

- 32 x 32-bit MIPS general-purpose register file for the pipelined processor.
- Two combinational read ports serve decode and one synchronous write port serves writeback (W stage).
- A per-register busy scoreboard: decode reserves a destination, writeback clears it, and each read port reports a hazard flag so the hazard unit can stall.
- $zero is hardwired to 0 and is never busy.

---
 rtl/register_file_pkg.sv | 11 +
 rtl/register_file_if.sv | 32 +++
 rtl/rf_read_port.sv | 36 +++
 rtl/register_file.sv | 62 ++++++
 tb/tb_register_file.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/register_file_pkg.sv
// Shared constants for the 32 x 32-bit MIPS general-purpose register file.
// REG_ZERO names the hardwired $zero index.
package register_file_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

  localparam logic [ADDR_WIDTH-1:0] REG_ZERO = '0;

endpackage

// File: rtl/register_file_if.sv
// Decode/writeback bus for the register file: two read ports, busy reservation,
// and the W-stage write. The master side drives it and the register file is the slave.
interface register_file_if
  import register_file_pkg::*;
();

  logic [ADDR_WIDTH-1:0] index1;
  logic [ADDR_WIDTH-1:0] index2;
  logic [ADDR_WIDTH-1:0] destIndex;
  logic [ADDR_WIDTH-1:0] writeIndexW;
  logic [DATA_WIDTH-1:0] valueInput;
  logic [DATA_WIDTH-1:0] valueOutput1;
  logic [DATA_WIDTH-1:0] valueOutput2;
  logic                  readEnable;
  logic                  writeEnable;
  logic                  regWriteW;
  logic                  flagOutput1;
  logic                  flagOutput2;

  modport master (
    output index1, index2, destIndex, writeIndexW, valueInput,
    output readEnable, writeEnable, regWriteW,
    input  valueOutput1, valueOutput2, flagOutput1, flagOutput2
  );

  modport slave (
    input  index1, index2, destIndex, writeIndexW, valueInput,
    input  readEnable, writeEnable, regWriteW,
    output valueOutput1, valueOutput2, flagOutput1, flagOutput2
  );

endinterface

// File: rtl/rf_read_port.sv
// One combinational read port: $zero forcing, writeback bypass and hazard flag.
// A same-cycle retiring write both supplies the data and resolves the hazard.
module rf_read_port
  import register_file_pkg::*;
(
  input  logic                  read_enable,
  input  logic [ADDR_WIDTH-1:0] index,
  input  logic [DATA_WIDTH-1:0] reg_value,
  input  logic                  busy_bit,
  input  logic                  reg_write_w,
  input  logic [ADDR_WIDTH-1:0] write_index_w,
  input  logic [DATA_WIDTH-1:0] value_input,
  output logic [DATA_WIDTH-1:0] value,
  output logic                  flag
);

  logic wb_hit;

  assign wb_hit = reg_write_w && (write_index_w == index);

  always_comb begin
    value = '0;
    flag  = 1'b0;
    if (read_enable) begin
      if (index == REG_ZERO) begin
        value = '0;
      end else if (wb_hit) begin
        value = value_input;
      end else begin
        value = reg_value;
      end
      flag = busy_bit && !wb_hit;
    end
  end

endmodule

// File: rtl/register_file.sv
// 32 x 32-bit register file with one synchronous write port, two bypassed read
// ports and a per-register busy scoreboard for decode-stage hazard detection.
module register_file
  import register_file_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  register_file_if.slave  rf
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;

  logic [DATA_WIDTH-1:0] reg_value1;
  logic [DATA_WIDTH-1:0] reg_value2;

  // Reservation is applied after the retire clear so a same-index set wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      busy <= '0;
    end else begin
      if (rf.regWriteW && (rf.writeIndexW != REG_ZERO)) begin
        regs[rf.writeIndexW] <= rf.valueInput;
        busy[rf.writeIndexW] <= 1'b0;
      end
      if (rf.writeEnable && (rf.destIndex != REG_ZERO)) begin
        busy[rf.destIndex] <= 1'b1;
      end
    end
  end

  assign reg_value1 = regs[rf.index1];
  assign reg_value2 = regs[rf.index2];

  rf_read_port u_read_port1 (
    .read_enable   (rf.readEnable),
    .index         (rf.index1),
    .reg_value     (reg_value1),
    .busy_bit      (busy[rf.index1]),
    .reg_write_w   (rf.regWriteW),
    .write_index_w (rf.writeIndexW),
    .value_input   (rf.valueInput),
    .value         (rf.valueOutput1),
    .flag          (rf.flagOutput1)
  );

  rf_read_port u_read_port2 (
    .read_enable   (rf.readEnable),
    .index         (rf.index2),
    .reg_value     (reg_value2),
    .busy_bit      (busy[rf.index2]),
    .reg_write_w   (rf.regWriteW),
    .write_index_w (rf.writeIndexW),
    .value_input   (rf.valueInput),
    .value         (rf.valueOutput2),
    .flag          (rf.flagOutput2)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: stimulus pushes expected read-port values
// into a queue and a negedge monitor pops and compares them.
module tb_register_file;
  import register_file_pkg::*;

  logic clk;
  logic reset;

  register_file_if rf ();

  register_file dut (
    .clk   (clk),
    .reset (reset),
    .rf    (rf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string                 name;
    logic [DATA_WIDTH-1:0] v1;
    logic [DATA_WIDTH-1:0] v2;
    logic                  f1;
    logic                  f2;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic chk;
  int   total;
  int   bad;

  // Inputs change #1 after the rising edge; combinational outputs settle by negedge.
  task automatic tick();
    chk = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_tick(input string nm,
                             input logic [DATA_WIDTH-1:0] v1,
                             input logic [DATA_WIDTH-1:0] v2,
                             input logic f1,
                             input logic f2);
    exp_t e;
    e.name = nm;
    e.v1   = v1;
    e.v2   = v2;
    e.f1   = f1;
    e.f2   = f2;
    exp_q.push_back(e);
    chk = 1'b1;
    @(posedge clk);
    #1;
    chk = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL monitor: output sampled with empty expectation queue");
      end else begin
        mon_e = exp_q.pop_front();
        total++;
        if (rf.valueOutput1 !== mon_e.v1) begin
          bad++;
          $display("FAIL %s valueOutput1 got %h want %h", mon_e.name, rf.valueOutput1, mon_e.v1);
        end
        total++;
        if (rf.valueOutput2 !== mon_e.v2) begin
          bad++;
          $display("FAIL %s valueOutput2 got %h want %h", mon_e.name, rf.valueOutput2, mon_e.v2);
        end
        total++;
        if (rf.flagOutput1 !== mon_e.f1) begin
          bad++;
          $display("FAIL %s flagOutput1 got %b want %b", mon_e.name, rf.flagOutput1, mon_e.f1);
        end
        total++;
        if (rf.flagOutput2 !== mon_e.f2) begin
          bad++;
          $display("FAIL %s flagOutput2 got %b want %b", mon_e.name, rf.flagOutput2, mon_e.f2);
        end
      end
    end
  end

  initial begin
    int drain;
    total = 0;
    bad   = 0;
    chk   = 1'b0;
    reset = 1'b1;
    rf.index1      = '0;
    rf.index2      = '0;
    rf.destIndex   = '0;
    rf.writeIndexW = '0;
    rf.valueInput  = '0;
    rf.readEnable  = 1'b0;
    rf.writeEnable = 1'b0;
    rf.regWriteW   = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    rf.readEnable = 1'b1; rf.index1 = 5'd1; rf.index2 = 5'd31;
    expect_tick("reset_state", 32'd0, 32'd0, 1'b0, 1'b0);

    rf.regWriteW = 1'b1; rf.writeIndexW = 5'd1; rf.valueInput = 32'h0000_0002;
    expect_tick("wr1_bypass", 32'd2, 32'd0, 1'b0, 1'b0);

    rf.regWriteW = 1'b0;
    expect_tick("rd1", 32'd2, 32'd0, 1'b0, 1'b0);

    rf.readEnable = 1'b0;
    expect_tick("read_disabled", 32'd0, 32'd0, 1'b0, 1'b0);

    rf.readEnable = 1'b1; rf.index2 = 5'd5;
    rf.regWriteW = 1'b1; rf.writeIndexW = 5'd5; rf.valueInput = 32'd7;
    expect_tick("wr5_seven", 32'd2, 32'd7, 1'b0, 1'b0);

    rf.valueInput = 32'd9;
    expect_tick("bypass5", 32'd2, 32'd9, 1'b0, 1'b0);

    rf.regWriteW = 1'b0;
    expect_tick("after5", 32'd2, 32'd9, 1'b0, 1'b0);

    rf.index1 = 5'd0; rf.index2 = 5'd0;
    rf.regWriteW = 1'b1; rf.writeIndexW = 5'd0; rf.valueInput = 32'hFFFF_FFFF;
    rf.writeEnable = 1'b1; rf.destIndex = 5'd0;
    expect_tick("zero_same", 32'd0, 32'd0, 1'b0, 1'b0);

    rf.regWriteW = 1'b0; rf.writeEnable = 1'b0;
    expect_tick("zero_after", 32'd0, 32'd0, 1'b0, 1'b0);

    rf.index1 = 5'd3; rf.index2 = 5'd3;
    rf.writeEnable = 1'b1; rf.destIndex = 5'd3;
    expect_tick("reserve_now", 32'd0, 32'd0, 1'b0, 1'b0);

    rf.writeEnable = 1'b0;
    expect_tick("busy3", 32'd0, 32'd0, 1'b1, 1'b1);

    rf.index2 = 5'd5;
    rf.regWriteW = 1'b1; rf.writeIndexW = 5'd3; rf.valueInput = 32'd4;
    expect_tick("retire3", 32'd4, 32'd9, 1'b0, 1'b0);

    rf.regWriteW = 1'b0; rf.index2 = 5'd3;
    expect_tick("cleared3", 32'd4, 32'd4, 1'b0, 1'b0);

    rf.writeEnable = 1'b1; rf.destIndex = 5'd3;
    rf.regWriteW = 1'b1; rf.writeIndexW = 5'd3; rf.valueInput = 32'd6;
    expect_tick("set_clear3", 32'd6, 32'd6, 1'b0, 1'b0);

    rf.writeEnable = 1'b0; rf.regWriteW = 1'b0;
    expect_tick("set_wins3", 32'd6, 32'd6, 1'b1, 1'b1);

    rf.writeEnable = 1'b1; rf.destIndex = 5'd3;
    rf.regWriteW = 1'b1; rf.writeIndexW = 5'd3; rf.valueInput = 32'd4;
    expect_tick("rewrite3", 32'd4, 32'd4, 1'b0, 1'b0);

    rf.writeEnable = 1'b0; rf.regWriteW = 1'b0; rf.index2 = 5'd5;
    expect_tick("pre_reset", 32'd4, 32'd9, 1'b1, 1'b0);

    reset = 1'b1;
    rf.regWriteW = 1'b1; rf.writeIndexW = 5'd3; rf.valueInput = 32'd8;
    rf.writeEnable = 1'b1; rf.destIndex = 5'd5;
    expect_tick("reset_cycle", 32'd8, 32'd9, 1'b0, 1'b0);

    reset = 1'b0; rf.regWriteW = 1'b0; rf.writeEnable = 1'b0;
    expect_tick("post_reset", 32'd0, 32'd0, 1'b0, 1'b0);

    rf.index1 = 5'd31; rf.index2 = 5'd1;
    rf.regWriteW = 1'b1; rf.writeIndexW = 5'd31; rf.valueInput = 32'hA5A5_5A5A;
    rf.writeEnable = 1'b1; rf.destIndex = 5'd31;
    expect_tick("wr31_resv31", 32'hA5A5_5A5A, 32'd0, 1'b0, 1'b0);

    rf.regWriteW = 1'b0; rf.writeEnable = 1'b0; rf.readEnable = 1'b0;
    expect_tick("disabled_busy31", 32'd0, 32'd0, 1'b0, 1'b0);

    rf.readEnable = 1'b1; rf.index2 = 5'd31;
    expect_tick("busy31", 32'hA5A5_5A5A, 32'hA5A5_5A5A, 1'b1, 1'b1);

    drain = 0;
    while (exp_q.size() != 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
